// File: rtl/cpu_boot_pkg.sv
// Shared state encoding and default sizes for the CPU boot loader.
package cpu_boot_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_ERROR
  } boot_state_e;

  localparam int IMEM_DEPTH_DEF = 256;
  localparam int DMEM_DEPTH_DEF = 1024;
  localparam int NUM_REGS_DEF   = 32;
  localparam int WORD_W_DEF     = 32;
  localparam logic [31:0] NOP_WORD = 32'b10011;
endpackage

// File: rtl/boot_word_sink.sv
// Program-word sink: valid/ready acceptance, instruction write pointer and
// overflow detection. Write requests are combinational; the top registers them.
module boot_word_sink #(
  parameter int DEPTH  = 256,
  parameter int WORD_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              s_valid_i,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              wr_o,
  output logic [AW-1:0]     wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  output logic              last_o,
  output logic              ovf_o
);
  logic [AW:0] ptr_q, ptr_d;
  logic        ready_q, ready_d;
  logic        xfer, full;

  // ptr carries one extra bit so "memory full" is distinct from address 0
  assign xfer      = s_valid_i && ready_q;
  assign full      = (ptr_q == (AW+1)'(DEPTH));
  assign wr_o      = xfer && !full;
  assign wr_addr_o = ptr_q[AW-1:0];
  assign wr_data_o = s_data_i;
  assign last_o    = wr_o && s_last_i;
  assign ovf_o     = xfer && full;
  assign s_ready_o = ready_q;

  always_comb begin
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (arm_i) begin
      ptr_d   = '0;
      ready_d = 1'b1;
    end else begin
      if (wr_o) ptr_d = ptr_q + (AW+1)'(1);
      if (last_o || ovf_o) ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: rtl/cpu_boot_loader.sv
// Boot sequencer: zero-fills DMEM/IMEM/RF, streams a program into IMEM, then
// releases the CPU. All outputs come straight from flops.
//   state    | meaning
//   IDLE     | CPU held in reset, waiting for go_i
//   CLEAR    | one word per cycle into every memory still in range
//   LOAD     | accepting program words, one-cycle write latency
//   RUN      | CPU out of reset and started; go_i reloads
//   ERROR    | program overflowed IMEM; go_i or reset exits
module cpu_boot_loader import cpu_boot_pkg::*; #(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  localparam int IAW       = $clog2(IMEM_DEPTH),
  localparam int DAW       = $clog2(DMEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              imem_we_o,
  output logic [IAW-1:0]    imem_addr_o,
  output logic [WORD_W-1:0] imem_data_o,
  output logic              dmem_we_o,
  output logic [DAW-1:0]    dmem_addr_o,
  output logic [WORD_W-1:0] dmem_data_o,
  output logic              rf_we_o,
  output logic [4:0]        rf_addr_o,
  output logic [WORD_W-1:0] rf_data_o,
  output logic              cpu_rst_o,
  output logic              cpu_start_o,
  output logic              done_o,
  output logic              err_o
);
  boot_state_e       state_q, state_d;
  logic [DAW-1:0]    idx_q, idx_d;
  logic              fin_q;
  logic              imem_we_q, imem_we_d, dmem_we_q, dmem_we_d, rf_we_q, rf_we_d;
  logic [IAW-1:0]    imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0] imem_data_q, imem_data_d;
  logic [DAW-1:0]    dmem_addr_q, dmem_addr_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic              run_q, run_d, err_q, err_d;
  logic              arm, sink_wr, sink_last, sink_ovf;
  logic [IAW-1:0]    sink_addr;
  logic [WORD_W-1:0] sink_data;

  boot_word_sink #(.DEPTH(IMEM_DEPTH), .WORD_W(WORD_W)) u_sink (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .arm_i     (arm),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_last_i  (s_last_i),
    .s_ready_o (s_ready_o),
    .wr_o      (sink_wr),
    .wr_addr_o (sink_addr),
    .wr_data_o (sink_data),
    .last_o    (sink_last),
    .ovf_o     (sink_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      fin_q       <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      run_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fin_q       <= sink_last;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      run_q       <= run_d;
      err_q       <= err_d;
    end
  end

  // fin_q marks the cycle the last word is being written; RUN follows it
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (go_i) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (idx_q == DAW'(DMEM_DEPTH - 1)) state_d = ST_LOAD;
        else idx_d = idx_q + DAW'(1);
      end
      ST_LOAD: begin
        if (sink_ovf) state_d = ST_ERROR;
        else if (fin_q) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign arm = (state_q == ST_CLEAR) && (state_d == ST_LOAD);

  always_comb begin
    dmem_we_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    if (state_d == ST_CLEAR) begin
      dmem_we_d   = 1'b1;
      dmem_addr_d = idx_d;
      if (int'(idx_d) < IMEM_DEPTH) begin
        imem_we_d   = 1'b1;
        imem_addr_d = idx_d[IAW-1:0];
        imem_data_d = '0;
      end
      if (int'(idx_d) < NUM_REGS) begin
        rf_we_d   = 1'b1;
        rf_addr_d = idx_d[4:0];
      end
    end else if (sink_wr) begin
      imem_we_d   = 1'b1;
      imem_addr_d = sink_addr;
      imem_data_d = sink_data;
    end
    run_d = (state_d == ST_RUN);
    err_d = (state_d == ST_ERROR);
  end

  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = dmem_addr_q;
  assign dmem_data_o = '0;
  assign rf_we_o     = rf_we_q;
  assign rf_addr_o   = rf_addr_q;
  assign rf_data_o   = '0;
  assign cpu_rst_o   = run_q;
  assign cpu_start_o = run_q;
  assign done_o      = run_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_cpu_boot_loader.sv
// Bench for cpu_boot_loader: table of load scenarios plus reset/overflow sequences,
// with a shadow IMEM built from observed writes compared to the intended program.
module tb_cpu_boot_loader;
  import cpu_boot_pkg::*;

  localparam int IMEM = 256;
  localparam int DMEM = 1024;
  localparam int NREG = 32;

  logic        clk_i = 1'b0;
  logic        rst_i, go_i, s_valid_i, s_last_i;
  logic [31:0] s_data_i;
  logic        s_ready_o, imem_we_o, dmem_we_o, rf_we_o;
  logic [7:0]  imem_addr_o;
  logic [9:0]  dmem_addr_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] imem_data_o, dmem_data_o, rf_data_o;
  logic        cpu_rst_o, cpu_start_o, done_o, err_o;

  cpu_boot_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .go_i(go_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .cpu_rst_o(cpu_rst_o), .cpu_start_o(cpu_start_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int n;
    int gap;        // idle cycles between beats; -1 = random 0..3
    bit fixed;      // use the hand-picked program words
    bit mark_last;
    bit exp_err;
    int exp_writes;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] fixed_w [3];
  logic [31:0] shadow [IMEM];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
    if (imem_we_o === 1'b1) shadow[imem_addr_o] = imem_data_o;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({s_ready_o, imem_we_o, dmem_we_o, rf_we_o,
                             cpu_rst_o, cpu_start_o, done_o, err_o}), 64'd0);
    chk({tag, "_addr"}, 64'({imem_addr_o, dmem_addr_o, rf_addr_o}), 64'd0);
    chk({tag, "_data"}, 64'(imem_data_o | dmem_data_o | rf_data_o), 64'd0);
  endtask

  task automatic do_clear(input int inject_go);
    logic [63:0] a, e;
    go_i = 1'b1;
    step;
    go_i = 1'b0;
    for (int k = 0; k < DMEM; k++) begin
      a = 64'({dmem_we_o, dmem_addr_o, imem_we_o, (imem_we_o ? imem_addr_o : 8'h0),
               rf_we_o, (rf_we_o ? rf_addr_o : 5'h0), |dmem_data_o,
               (imem_we_o & (|imem_data_o)), |rf_data_o,
               cpu_rst_o, cpu_start_o, done_o, err_o, s_ready_o});
      e = 64'({1'b1, 10'(k), 1'(k < IMEM), ((k < IMEM) ? 8'(k) : 8'h0),
               1'(k < NREG), ((k < NREG) ? 5'(k) : 5'h0), 8'h0});
      chk("clear_cycle", a, e);
      if (k == inject_go) go_i = 1'b1;
      step;
      go_i = 1'b0;
    end
    chk("load_entry", 64'({dmem_we_o, imem_we_o, rf_we_o, s_ready_o, cpu_rst_o}), 64'b00010);
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] words [$];
    int          gaps [$];
    int          t, exp_cycles, steps;
    logic [31:0] w, exp_w;
    t = 0;
    for (int i = 0; i < v.n; i++) begin
      if (v.fixed) w = (v.n == 1) ? NOP_WORD : fixed_w[i];
      else w = $urandom;
      words.push_back(w);
      gaps.push_back((i == 0) ? 0 : ((v.gap < 0) ? int'($urandom_range(0, 3)) : v.gap));
      t = (i == 0) ? gaps[i] : t + 1 + gaps[i];
    end
    exp_cycles = t + 2;
    steps = 0;
    for (int i = 0; i < v.n; i++) begin
      repeat (gaps[i]) begin
        s_valid_i = 1'b0;
        step;
        steps++;
        chk("gap_nowrite", 64'(imem_we_o), 64'd0);
      end
      s_valid_i = 1'b1;
      s_data_i  = words[i];
      s_last_i  = v.mark_last && (i == v.n - 1);
      step;
      steps++;
      if (i < IMEM)
        chk("beat_write", 64'({imem_we_o, imem_addr_o, imem_data_o}), 64'({1'b1, 8'(i), words[i]}));
      else
        chk("ovf_beat", 64'({imem_we_o, err_o, s_ready_o, cpu_rst_o, done_o}), 64'b01000);
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    if (v.exp_err) begin
      step;
      chk("error_hold", 64'({err_o, s_ready_o, cpu_rst_o, imem_we_o}), 64'b1000);
    end else begin
      chk("ready_drop", 64'({s_ready_o, done_o, cpu_rst_o}), 64'd0);
      step;
      steps++;
      chk("run_entry", 64'({cpu_rst_o, cpu_start_o, done_o, err_o, s_ready_o, imem_we_o}),
          64'b111000);
      chk("load_cycles", 64'(steps), 64'(exp_cycles));
    end
    for (int j = 0; j < IMEM; j++) begin
      exp_w = (j < v.exp_writes) ? words[j] : 32'h0;
      chk("imem_word", 64'(shadow[j]), 64'(exp_w));
    end
  endtask

  task automatic reset_mid_clear;
    go_i = 1'b1;
    step;
    go_i = 1'b0;
    repeat (500) step;
    chk("pre_reset_addr", 64'({dmem_we_o, dmem_addr_o}), 64'({1'b1, 10'd500}));
    rst_i = 1'b0;
    #2;
    check_reset("async_reset");
    #3;
    rst_i = 1'b1;
    step;
    chk("post_reset_idle", 64'({dmem_we_o, cpu_rst_o, s_ready_o}), 64'd0);
  endtask

  initial begin
    fixed_w[0] = 32'h00500093;
    fixed_w[1] = 32'h00A00113;
    fixed_w[2] = 32'h002081B3;
    vecs[0] = '{n: 3,   gap: 0,  fixed: 1'b1, mark_last: 1'b1, exp_err: 1'b0, exp_writes: 3};
    vecs[1] = '{n: 3,   gap: 2,  fixed: 1'b1, mark_last: 1'b1, exp_err: 1'b0, exp_writes: 3};
    vecs[2] = '{n: 257, gap: 0,  fixed: 1'b0, mark_last: 1'b0, exp_err: 1'b1, exp_writes: 256};
    vecs[3] = '{n: 1,   gap: 0,  fixed: 1'b1, mark_last: 1'b1, exp_err: 1'b0, exp_writes: 1};
    vecs[4] = '{n: 20,  gap: -1, fixed: 1'b0, mark_last: 1'b1, exp_err: 1'b0, exp_writes: 20};
    vecs[5] = '{n: 256, gap: 0,  fixed: 1'b0, mark_last: 1'b1, exp_err: 1'b0, exp_writes: 256};
    vecs[6] = '{n: 1,   gap: 0,  fixed: 1'b1, mark_last: 1'b1, exp_err: 1'b0, exp_writes: 1};
    for (int j = 0; j < IMEM; j++) shadow[j] = 'x;

    rst_i = 1'b1; go_i = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = '0;
    #1 rst_i = 1'b0;
    #10;
    check_reset("por");
    @(negedge clk_i);
    rst_i = 1'b1;
    s_valid_i = 1'b1;
    step;
    step;
    chk("idle_ignores_valid", 64'({s_ready_o, imem_we_o, dmem_we_o, cpu_rst_o}), 64'd0);
    s_valid_i = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (v == 4) reset_mid_clear();
      do_clear((v == 0) ? 100 : -1);
      run_load(vecs[v]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
